interupt_responder: RTL and testbench
=====================================

Name: interupt_responder

Overview:
- CPU-side end of the interrupt bus: takes the 32-bit interrupt vector driven by the interrupt aggregator and returns the 32-bit acknowledge vector to it.
- Registers and masks the incoming requests, then selects the highest-priority pending line.
- Presents that line to the CPU core with a request/taken/done handshake.
- Issues a single-cycle acknowledge pulse on the serviced bit, then waits for the source to drop before arbitrating again.

Parameters:
RESET_MASK, 32'hFF00_0000, enable mask value loaded on reset (bits 31..24 enabled).
ACK_TIMEOUT, 255, cycles to wait in CLEAR for the source to deassert; 0 = wait indefinitely.

Ports:
system_clock  in  1  single clock, rising edge.
system_reset  in  1  asynchronous, active-high reset.
interupt_in  in  32  level interrupt requests from the aggregator.
interupt_ack  out  32  acknowledge vector to the aggregator; at most one bit high, for one cycle.
mask_write  in  1  load mask_data into the enable mask.
mask_data  in  32  new enable mask.
mask_value  out  32  current enable mask.
cpu_irq  out  1  interrupt request to the CPU core.
cpu_irq_vector  out  5  index of the requested line, valid while cpu_irq or busy is high.
cpu_irq_taken  in  1  CPU accepts the request (single-cycle strobe).
cpu_irq_done  in  1  CPU has finished the ISR (single-cycle strobe).
busy  out  1  high in every state except IDLE.
spurious_count  out  8  saturating count of requests withdrawn before they were taken.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; interupt_ack=0; cpu_irq=0; cpu_irq_vector=0; busy=0; mask_value=RESET_MASK; pending_r=0; spurious_count=0; timeout counter=0. No ack pulse is emitted for an interrupted service.
- Sampling: pending_r <= interupt_in & mask_value every cycle.
  - Total latency from interupt_in rising (sampled at edge N) to cpu_irq high is 2 edges: pending_r updates at N, cpu_irq is registered at N+1.
- Mask: on mask_write, mask_value <= mask_data. It affects pending_r from the next edge.
- Priority: the highest set index of pending_r wins (bit 31 highest). The vector is encoded as 5 bits.
- IDLE:
  - If pending_r != 0: latch the winning index into cpu_irq_vector, set cpu_irq=1, go REQUEST.
  - Otherwise stay in IDLE.
- REQUEST: cpu_irq held high; cpu_irq_vector stable.
  - If pending_r[vector]==0 (source dropped or masked): cpu_irq<=0, spurious_count+1 (saturates at 255), go IDLE. This check takes precedence over cpu_irq_taken in the same cycle.
  - Else if cpu_irq_taken: cpu_irq<=0, go SERVICE.
  - A newly arriving higher-priority request does not pre-empt the latched vector.
- SERVICE:
  - Wait for cpu_irq_done, regardless of the source level.
  - On cpu_irq_done: interupt_ack <= one-hot(vector) for exactly one cycle, load the timeout counter, go CLEAR.
  - cpu_irq_taken is ignored in this state.
- CLEAR: interupt_ack returns to 0 on the first cycle in CLEAR.
  - If interupt_in[vector]==0 (raw input, unmasked): go IDLE.
  - Else if ACK_TIMEOUT!=0 and the counter reaches 0: go IDLE. A source still high is then treated as a new request.
  - Otherwise decrement the counter.
- cpu_irq_done or cpu_irq_taken arriving in IDLE or CLEAR is ignored.
- interupt_ack bits that no source uses (23..0 under the default mask) are still driven when their index wins.

Test Plan:
1. Single request: interupt_in=32'h0100_0000 asserted at edge 0 -> cpu_irq=1, cpu_irq_vector=24 at edge 2; taken at edge 5 -> cpu_irq=0; done at edge 10 -> interupt_ack=32'h0100_0000 for one cycle at edge 11; drop interupt_in -> busy=0 one cycle later.
2. Priority: interupt_in=32'h8200_0000 -> vector 31 serviced first and acked with 32'h8000_0000; bit 31 drops -> next request presents vector 25.
3. Masking and reset: with the default mask, interupt_in=32'h0000_0001 -> cpu_irq stays 0; mask_write with 32'h0000_0001 -> vector 0 requested 2 cycles later. Reset asserted mid-SERVICE -> all outputs 0 immediately, no ack pulse, mask_value=32'hFF00_0000.
4. Spurious: raise bit 28, drop it while in REQUEST before taken -> cpu_irq falls, spurious_count=1, no ack. Repeat 300 times -> count saturates at 255.
5. Stuck source: ACK_TIMEOUT=4, bit 30 held high through done -> CLEAR exits after 4 cycles and bit 30 is re-requested (second ack observed). Drop and taken in the same REQUEST cycle -> treated as spurious.

Source files
------------

// File: rtl/interupt_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : interupt_responder_if
// Description : Bus bundle between the interrupt aggregator / CPU core and the
//               interrupt responder.
//               master : the aggregator/CPU side. It drives requests, mask
//                        writes and the taken/done strobes.
//               slave  : the responder. It drives acknowledge, mask readback,
//                        the CPU request, busy and spurious_count.
// Revision    : 1.0 - initial release
// ============================================================================
interface interupt_responder_if;
  logic [31:0] interupt_in;
  logic [31:0] interupt_ack;
  logic        mask_write;
  logic [31:0] mask_data;
  logic [31:0] mask_value;
  logic        cpu_irq;
  logic [4:0]  cpu_irq_vector;
  logic        cpu_irq_taken;
  logic        cpu_irq_done;
  logic        busy;
  logic [7:0]  spurious_count;

  modport master (
    output interupt_in, mask_write, mask_data, cpu_irq_taken, cpu_irq_done,
    input  interupt_ack, mask_value, cpu_irq, cpu_irq_vector, busy, spurious_count
  );

  modport slave (
    input  interupt_in, mask_write, mask_data, cpu_irq_taken, cpu_irq_done,
    output interupt_ack, mask_value, cpu_irq, cpu_irq_vector, busy, spurious_count
  );
endinterface
`default_nettype wire

// File: rtl/interupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : interupt_responder
// Description : CPU-side interrupt responder. It registers and masks 32 level
//               requests and picks the highest pending index. It hands that
//               index to the CPU with a request/taken/done handshake. It then
//               pulses a one-hot acknowledge and waits (with an optional
//               timeout) for the source to drop.
// Ports       : system_clock - rising-edge clock
//               system_reset - asynchronous active-high reset
//               bus          - interupt_responder_if.slave (requests, ack,
//                              mask write/readback, CPU handshake, status)
// Revision    : 1.0 - initial release
// ============================================================================
module interupt_responder #(
  parameter logic [31:0] RESET_MASK  = 32'hFF00_0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  wire logic             system_clock,
  input  wire logic             system_reset,
  interupt_responder_if.slave   bus
);

  localparam logic [31:0] TIMEOUT_LOAD = 32'(ACK_TIMEOUT);
  localparam bit          TIMEOUT_EN   = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pending_r;
  logic [31:0] mask_r;
  logic [31:0] ack_r, ack_next;
  logic        irq_r, irq_next;
  logic [4:0]  vec_r, vec_next;
  logic [7:0]  spur_r, spur_next;
  logic [31:0] cnt_r, cnt_next;
  logic [4:0]  win_idx;

  // Highest set bit wins, so the last hit in an ascending scan is kept.
  always_comb begin
    win_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (pending_r[i]) win_idx = 5'(i);
    end
  end

  // Sampling and mask. A mask write only reaches pending_r on the next edge.
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      mask_r    <= RESET_MASK;
      pending_r <= 32'd0;
    end else begin
      pending_r <= bus.interupt_in & mask_r;
      if (bus.mask_write) mask_r <= bus.mask_data;
    end
  end

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state  <= IDLE;
      ack_r  <= 32'd0;
      irq_r  <= 1'b0;
      vec_r  <= 5'd0;
      spur_r <= 8'd0;
      cnt_r  <= 32'd0;
    end else begin
      state  <= state_next;
      ack_r  <= ack_next;
      irq_r  <= irq_next;
      vec_r  <= vec_next;
      spur_r <= spur_next;
      cnt_r  <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    ack_next   = 32'd0;   // ack is a one-cycle pulse by default
    irq_next   = irq_r;
    vec_next   = vec_r;
    spur_next  = spur_r;
    cnt_next   = cnt_r;
    unique case (state)
      IDLE: begin
        if (pending_r != 32'd0) begin
          vec_next   = win_idx;
          irq_next   = 1'b1;
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        // A withdrawn request beats a same-cycle taken strobe.
        if (!pending_r[vec_r]) begin
          irq_next   = 1'b0;
          state_next = IDLE;
          if (spur_r != 8'hFF) spur_next = spur_r + 8'd1;
        end else if (bus.cpu_irq_taken) begin
          irq_next   = 1'b0;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.cpu_irq_done) begin
          ack_next   = 32'd1 << vec_r;
          cnt_next   = TIMEOUT_LOAD;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        // The raw input is checked here: a source masked during service must
        // still be seen to drop. The counter exits when it reaches zero, so
        // ACK_TIMEOUT=N gives N cycles in CLEAR.
        if (!bus.interupt_in[vec_r]) begin
          state_next = IDLE;
        end else if (TIMEOUT_EN && cnt_r <= 32'd1) begin
          cnt_next   = 32'd0;
          state_next = IDLE;
        end else if (cnt_r != 32'd0) begin
          cnt_next = cnt_r - 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.interupt_ack    = ack_r;
  assign bus.mask_value      = mask_r;
  assign bus.cpu_irq         = irq_r;
  assign bus.cpu_irq_vector  = vec_r;
  assign bus.busy            = (state != IDLE);
  assign bus.spurious_count  = spur_r;

endmodule
`default_nettype wire

// File: tb/tb_interupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_interupt_responder
// Description : Directed self-checking bench for interupt_responder
//               (ACK_TIMEOUT=4, default reset mask).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interupt_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  interupt_responder_if bus();

  interupt_responder #(.RESET_MASK(32'hFF00_0000), .ACK_TIMEOUT(4)) dut (
    .system_clock (clk),
    .system_reset (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.interupt_in = 32'd0; bus.mask_write = 1'b0; bus.mask_data = 32'd0;
    bus.cpu_irq_taken = 1'b0; bus.cpu_irq_done = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    compared++; if (bus.interupt_ack !== 32'd0) begin mismatched++; $display("FAIL reset_ack: got %h want 0", bus.interupt_ack); end
    compared++; if (bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL reset_irq: got %b want 0", bus.cpu_irq); end
    compared++; if (bus.cpu_irq_vector !== 5'd0) begin mismatched++; $display("FAIL reset_vec: got %0d want 0", bus.cpu_irq_vector); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    compared++; if (bus.mask_value !== 32'hFF00_0000) begin mismatched++; $display("FAIL reset_mask: got %h want ff000000", bus.mask_value); end
    compared++; if (bus.spurious_count !== 8'd0) begin mismatched++; $display("FAIL reset_spur: got %0d want 0", bus.spurious_count); end
    // done/taken in IDLE are ignored
    bus.cpu_irq_done = 1'b1; bus.cpu_irq_taken = 1'b1; tick(1);
    bus.cpu_irq_done = 1'b0; bus.cpu_irq_taken = 1'b0; tick(1);
    compared++; if (bus.interupt_ack !== 32'd0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL idle_done: ack %h busy %b want 0/0", bus.interupt_ack, bus.busy); end
  endtask

  task automatic test_single();
    bus.interupt_in = 32'h0100_0000;
    tick(1);
    compared++; if (bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL single_lat1: irq %b want 0", bus.cpu_irq); end
    tick(1);
    compared++; if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_vector !== 5'd24 || bus.busy !== 1'b1) begin mismatched++; $display("FAIL single_req: irq %b vec %0d busy %b want 1/24/1", bus.cpu_irq, bus.cpu_irq_vector, bus.busy); end
    tick(2);
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    compared++; if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b1 || bus.interupt_ack !== 32'd0) begin mismatched++; $display("FAIL single_taken: irq %b busy %b ack %h want 0/1/0", bus.cpu_irq, bus.busy, bus.interupt_ack); end
    tick(3);
    bus.cpu_irq_done = 1'b1; tick(1); bus.cpu_irq_done = 1'b0;
    compared++; if (bus.interupt_ack !== 32'h0100_0000) begin mismatched++; $display("FAIL single_ack: got %h want 01000000", bus.interupt_ack); end
    tick(1);
    compared++; if (bus.interupt_ack !== 32'd0 || bus.busy !== 1'b1) begin mismatched++; $display("FAIL single_ack_pulse: ack %h busy %b want 0/1", bus.interupt_ack, bus.busy); end
    bus.interupt_in = 32'd0; tick(1);
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL single_idle: busy %b want 0", bus.busy); end
    tick(2);
    compared++; if (bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL single_no_rereq: irq %b want 0", bus.cpu_irq); end
  endtask

  task automatic test_priority();
    bus.interupt_in = 32'h8200_0000; tick(2);
    compared++; if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_vector !== 5'd31) begin mismatched++; $display("FAIL prio_first: irq %b vec %0d want 1/31", bus.cpu_irq, bus.cpu_irq_vector); end
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    bus.cpu_irq_done = 1'b1; tick(1); bus.cpu_irq_done = 1'b0;
    compared++; if (bus.interupt_ack !== 32'h8000_0000) begin mismatched++; $display("FAIL prio_ack31: got %h want 80000000", bus.interupt_ack); end
    bus.interupt_in = 32'h0200_0000; tick(2);
    compared++; if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_vector !== 5'd25) begin mismatched++; $display("FAIL prio_second: irq %b vec %0d want 1/25", bus.cpu_irq, bus.cpu_irq_vector); end
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    bus.cpu_irq_done = 1'b1; tick(1); bus.cpu_irq_done = 1'b0;
    compared++; if (bus.interupt_ack !== 32'h0200_0000) begin mismatched++; $display("FAIL prio_ack25: got %h want 02000000", bus.interupt_ack); end
    bus.interupt_in = 32'd0; tick(2);
  endtask

  task automatic test_mask_and_reset();
    bus.interupt_in = 32'h0000_0001; tick(3);
    compared++; if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL mask_blocked: irq %b busy %b want 0/0", bus.cpu_irq, bus.busy); end
    bus.mask_write = 1'b1; bus.mask_data = 32'h0000_0001; tick(1); bus.mask_write = 1'b0;
    compared++; if (bus.mask_value !== 32'h0000_0001 || bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL mask_write: mask %h irq %b want 00000001/0", bus.mask_value, bus.cpu_irq); end
    tick(1);
    compared++; if (bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL mask_lat: irq %b want 0", bus.cpu_irq); end
    tick(1);
    compared++; if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_vector !== 5'd0) begin mismatched++; $display("FAIL mask_req0: irq %b vec %0d want 1/0", bus.cpu_irq, bus.cpu_irq_vector); end
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    // taken again in SERVICE is ignored
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    compared++; if (bus.busy !== 1'b1 || bus.interupt_ack !== 32'd0 || bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL service_wait: busy %b ack %h irq %b want 1/0/0", bus.busy, bus.interupt_ack, bus.cpu_irq); end
    #2 rst = 1'b1; #1;
    compared++; if (bus.busy !== 1'b0 || bus.cpu_irq !== 1'b0 || bus.interupt_ack !== 32'd0 || bus.cpu_irq_vector !== 5'd0) begin mismatched++; $display("FAIL async_reset: busy %b irq %b ack %h vec %0d want 0/0/0/0", bus.busy, bus.cpu_irq, bus.interupt_ack, bus.cpu_irq_vector); end
    compared++; if (bus.mask_value !== 32'hFF00_0000) begin mismatched++; $display("FAIL async_reset_mask: got %h want ff000000", bus.mask_value); end
    tick(1); rst = 1'b0; bus.interupt_in = 32'd0;
    bus.cpu_irq_done = 1'b1; tick(1); bus.cpu_irq_done = 1'b0; tick(1);
    compared++; if (bus.interupt_ack !== 32'd0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_no_ack: ack %h busy %b want 0/0", bus.interupt_ack, bus.busy); end
  endtask

  task automatic test_drop_with_taken();
    bus.interupt_in = 32'h1000_0000; tick(2);
    compared++; if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_vector !== 5'd28) begin mismatched++; $display("FAIL dt_req: irq %b vec %0d want 1/28", bus.cpu_irq, bus.cpu_irq_vector); end
    bus.interupt_in = 32'd0; tick(1);
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    compared++; if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b0 || bus.spurious_count !== 8'd1) begin mismatched++; $display("FAIL dt_spurious: irq %b busy %b spur %0d want 0/0/1", bus.cpu_irq, bus.busy, bus.spurious_count); end
    tick(2);
    compared++; if (bus.interupt_ack !== 32'd0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL dt_no_ack: ack %h busy %b want 0/0", bus.interupt_ack, bus.busy); end
  endtask

  task automatic test_spurious();
    logic [7:0] want;
    int ack_seen = 0;
    for (int i = 0; i < 300; i++) begin
      bus.interupt_in = 32'h1000_0000; tick(2);
      bus.interupt_in = 32'd0; tick(1);
      if (bus.interupt_ack !== 32'd0) ack_seen++;
      tick(1);
      if (bus.interupt_ack !== 32'd0) ack_seen++;
      // One spurious event came from the earlier drop-with-taken case.
      if (i == 0 || i == 100 || i == 253 || i == 254) begin
        want = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
        compared++; if (bus.spurious_count !== want || bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL spur_count_%0d: spur %0d irq %b want %0d/0", i, bus.spurious_count, bus.cpu_irq, want); end
      end
    end
    compared++; if (bus.spurious_count !== 8'd255) begin mismatched++; $display("FAIL spur_saturate: got %0d want 255", bus.spurious_count); end
    compared++; if (ack_seen != 0) begin mismatched++; $display("FAIL spur_no_ack: ack cycles %0d want 0", ack_seen); end
  endtask

  task automatic test_stuck_source();
    bus.interupt_in = 32'h4000_0000; tick(2);
    compared++; if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_vector !== 5'd30) begin mismatched++; $display("FAIL stuck_req: irq %b vec %0d want 1/30", bus.cpu_irq, bus.cpu_irq_vector); end
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    bus.cpu_irq_done = 1'b1; tick(1); bus.cpu_irq_done = 1'b0;
    compared++; if (bus.interupt_ack !== 32'h4000_0000) begin mismatched++; $display("FAIL stuck_ack1: got %h want 40000000", bus.interupt_ack); end
    tick(3);
    compared++; if (bus.busy !== 1'b1 || bus.interupt_ack !== 32'd0) begin mismatched++; $display("FAIL stuck_clear4: busy %b ack %h want 1/0", bus.busy, bus.interupt_ack); end
    tick(1);
    compared++; if (bus.busy !== 1'b0 || bus.cpu_irq !== 1'b0) begin mismatched++; $display("FAIL stuck_timeout: busy %b irq %b want 0/0", bus.busy, bus.cpu_irq); end
    tick(1);
    compared++; if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_vector !== 5'd30) begin mismatched++; $display("FAIL stuck_rereq: irq %b vec %0d want 1/30", bus.cpu_irq, bus.cpu_irq_vector); end
    bus.cpu_irq_taken = 1'b1; tick(1); bus.cpu_irq_taken = 1'b0;
    bus.cpu_irq_done = 1'b1; tick(1); bus.cpu_irq_done = 1'b0;
    compared++; if (bus.interupt_ack !== 32'h4000_0000) begin mismatched++; $display("FAIL stuck_ack2: got %h want 40000000", bus.interupt_ack); end
    bus.interupt_in = 32'd0; tick(1);
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL stuck_release: busy %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_and_reset();
    test_drop_with_taken();
    test_spurious();
    test_stuck_source();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
